mouse_ps2_receiver: RTL and testbench

//  Device-to-host half of the PS/2 mouse link; complements the host-to-device transmitter.

---
 rtl/mouse_ps2_receiver_pkg.sv | 24 ++
 rtl/mouse_ps2_receiver_sync_edge.sv | 30 +++
 rtl/mouse_ps2_receiver.sv | 131 +++++++++++++
 tb/tb_mouse_ps2_receiver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_ps2_receiver_pkg.sv
// Shared definitions for the PS/2 mouse receiver: frame geometry, FSM states,
// error-code bit positions and the odd-parity helper.
package mouse_ps2_receiver_pkg;

  localparam int PS2_DATA_BITS = 8;
  localparam int BIT_CNT_W     = $clog2(PS2_DATA_BITS);

  // Bit positions inside BYTE_ERROR_CODE
  localparam int ERR_PARITY = 0;
  localparam int ERR_STOP   = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Parity bit a well-behaved device sends for this byte (odd parity overall)
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/mouse_ps2_receiver_sync_edge.sv
// Multi-flop synchroniser for one asynchronous PS/2 line plus a falling-edge
// detector on the synchronised level. Flops reset to 1 because the bus idles high.
module mouse_ps2_receiver_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw line through the synchroniser and keep the previous level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign fall_o  = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mouse_ps2_receiver.sv
// Device-to-host half of the PS/2 mouse link: deframes 11-bit frames (start,
// 8 data LSB-first, odd parity, stop) and hands each byte to the mouse master
// with a one-cycle strobe and parity/stop error flags. Abandoned frames
// (inter-edge timeout or READ_ENABLE withdrawn) raise a one-cycle FRAME_ABORT.
module mouse_ps2_receiver
  import mouse_ps2_receiver_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic       BYTE_READ,
  output logic [7:0] BYTE,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       FRAME_ABORT
);

  localparam int                     TIMER_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0]     TIMEOUT_LIMIT = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [BIT_CNT_W-1:0]   BIT_LAST      = BIT_CNT_W'(PS2_DATA_BITS - 1);

  logic clk_fall;
  logic clk_level_unused;   // only the edge of the clock line is needed
  logic data_sync;
  logic data_fall_unused;   // only the level of the data line is needed

  ps2_state_e                 state_q;
  logic [BIT_CNT_W-1:0]       bit_cnt_q;
  logic [PS2_DATA_BITS-1:0]   shreg_q;
  logic                       parity_q;
  logic [TIMER_W-1:0]         timer_q;
  logic [TIMER_W-1:0]         timer_d;
  logic [PS2_DATA_BITS-1:0]   byte_q;
  logic [1:0]                 err_q;
  logic                       byte_read_q;
  logic                       frame_abort_q;

  mouse_ps2_receiver_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .line_i  (CLK_MOUSE_IN),
    .level_o (clk_level_unused),
    .fall_o  (clk_fall)
  );

  mouse_ps2_receiver_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .line_i  (DATA_MOUSE_IN),
    .level_o (data_sync),
    .fall_o  (data_fall_unused)
  );

  // Saturating increment of the inter-edge timer
  always_comb begin
    // NOTE: every combinational output gets an unconditional value first so no latch is inferred.
    timer_d = timer_q;
    if (timer_q != TIMEOUT_LIMIT) timer_d = timer_q + 1'b1;
  end

  // Frame FSM with shift register, bit counter, timeout and registered outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      parity_q      <= 1'b0;
      timer_q       <= '0;
      byte_q        <= '0;
      err_q         <= '0;
      byte_read_q   <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in the same
      // cycle, which is what makes the strobes exactly one cycle wide.
      byte_read_q   <= 1'b0;
      frame_abort_q <= 1'b0;

      if (state_q == ST_IDLE) begin
        timer_q <= '0;
        if (clk_fall && READ_ENABLE && !data_sync) begin
          state_q   <= ST_DATA;
          bit_cnt_q <= '0;
        end
      end else if (!READ_ENABLE) begin
        // Transmitter has taken the bus: abandon the frame, beating any coincident edge
        state_q       <= ST_IDLE;
        timer_q       <= '0;
        frame_abort_q <= 1'b1;
      end else if (clk_fall) begin
        timer_q <= '0;
        case (state_q)
          ST_DATA: begin
            shreg_q[bit_cnt_q] <= data_sync;
            if (bit_cnt_q == BIT_LAST) state_q <= ST_PARITY;
            else                       bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          ST_PARITY: begin
            parity_q <= data_sync;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            byte_q            <= shreg_q;
            err_q[ERR_PARITY] <= (parity_q != odd_parity(shreg_q));
            err_q[ERR_STOP]   <= ~data_sync;
            byte_read_q       <= 1'b1;
            state_q           <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (timer_q >= TIMEOUT_LIMIT) begin
        // Mouse clock stalled mid-frame: drop the partial byte
        state_q       <= ST_IDLE;
        timer_q       <= '0;
        frame_abort_q <= 1'b1;
      end else begin
        timer_q <= timer_d;
      end
    end
  end

  assign BYTE_READ       = byte_read_q;
  assign BYTE            = byte_q;
  assign BYTE_ERROR_CODE = err_q;
  assign FRAME_ABORT     = frame_abort_q;

endmodule

// File: tb/tb_mouse_ps2_receiver.sv
// Bench for mouse_ps2_receiver: a PS/2 device model drives directed and random
// frames; expected bytes and error codes come from the frame contents alone.
module tb_mouse_ps2_receiver;

  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 50000;
  localparam int HALF           = 25;   // mouse clock half period in system cycles

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CLK_MOUSE_IN = 1'b1;
  logic       DATA_MOUSE_IN = 1'b1;
  logic       READ_ENABLE = 1'b0;
  logic       BYTE_READ;
  logic [7:0] BYTE;
  logic [1:0] BYTE_ERROR_CODE;
  logic       FRAME_ABORT;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fall = 0;
  int drop_cyc  = 0;

  logic [7:0] q_byte[$];
  logic [1:0] q_err[$];
  int         q_cyc[$];
  int         abort_cnt = 0;
  int         abort_cyc = 0;
  int         both_cnt  = 0;

  mouse_ps2_receiver #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .CLK_MOUSE_IN    (CLK_MOUSE_IN),
    .DATA_MOUSE_IN   (DATA_MOUSE_IN),
    .READ_ENABLE     (READ_ENABLE),
    .BYTE_READ       (BYTE_READ),
    .BYTE            (BYTE),
    .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
    .FRAME_ABORT     (FRAME_ABORT)
  );

  always #10 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record every strobe, sampled on the falling system clock edge
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (BYTE_READ) begin
        q_byte.push_back(BYTE);
        q_err.push_back(BYTE_ERROR_CODE);
        q_cyc.push_back(cyc);
      end
      if (FRAME_ABORT) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
      if (BYTE_READ && FRAME_ABORT) both_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Device model: drives the first nfalls bits of {stop, parity, data, start}.
  // Data changes while the clock is high; optionally leaves the clock low after
  // the last fall, and optionally withdraws READ_ENABLE after bit drop_at.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int nfalls, input bit stop_low, input int drop_at);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < nfalls; i++) begin
      DATA_MOUSE_IN = bits[i];
      tick(HALF);
      CLK_MOUSE_IN = 1'b0;
      last_fall = cyc;
      if (stop_low && i == nfalls - 1) return;
      tick(HALF);
      CLK_MOUSE_IN = 1'b1;
      if (i == drop_at) begin
        READ_ENABLE = 1'b0;
        drop_cyc = cyc;
      end
    end
    tick(HALF);
    DATA_MOUSE_IN = 1'b1;
  endtask

  function automatic logic good_parity(input logic [7:0] d);
    // parity bit that makes the total count of ones odd
    return ($countones(d) % 2) == 0;
  endfunction

  // Send one complete frame and verify exactly one strobe with the model's result
  task automatic run_frame(input logic [7:0] d, input logic p, input logic s, input string tag);
    int         a0;
    logic [1:0] exp_err;
    logic [7:0] got_b;
    logic [1:0] got_e;
    int         got_c;
    a0 = abort_cnt;
    exp_err[0] = ((($countones(d) + int'(p)) % 2) == 0);
    exp_err[1] = (s == 1'b0);
    send_frame(d, p, s, 11, 1'b0, -1);
    tick(8);
    check({tag, " strobes"}, q_byte.size(), 1);
    check({tag, " aborts"}, abort_cnt - a0, 0);
    if (q_byte.size() > 0) begin
      got_b = q_byte.pop_front();
      got_e = q_err.pop_front();
      got_c = q_cyc.pop_front();
      check({tag, " byte"}, got_b, d);
      check({tag, " err"}, got_e, exp_err);
      check({tag, " latency"}, got_c - last_fall, SYNC_STAGES + 1);
    end
    q_byte.delete(); q_err.delete(); q_cyc.delete();
    check({tag, " held byte"}, BYTE, d);
    check({tag, " held err"}, BYTE_ERROR_CODE, exp_err);
  endtask

  initial begin
    int a0;
    int waited;
    logic [7:0] rd;
    logic rp, rs;

    // Reset state
    tick(3);
    check("reset BYTE_READ", BYTE_READ, 0);
    check("reset FRAME_ABORT", FRAME_ABORT, 0);
    check("reset BYTE", BYTE, 0);
    check("reset ERR", BYTE_ERROR_CODE, 0);
    RESET_N = 1'b1;
    READ_ENABLE = 1'b1;
    tick(10);

    // Good frame, bad parity, bad stop
    run_frame(8'hFA, 1'b1, 1'b1, "fa_ok");
    run_frame(8'h08, 1'b1, 1'b1, "08_parity");
    run_frame(8'h08, 1'b0, 1'b0, "08_stop");

    // Clock stops after 4 data bits: timeout abort, byte unchanged
    a0 = abort_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 5, 1'b1, -1);
    waited = 0;
    while (abort_cnt == a0 && waited < TIMEOUT_CYCLES + 100) begin
      tick(1);
      waited++;
    end
    check("timeout abort count", abort_cnt - a0, 1);
    check("timeout abort window",
          ((abort_cyc - last_fall) >= TIMEOUT_CYCLES) &&
          ((abort_cyc - last_fall) <= TIMEOUT_CYCLES + SYNC_STAGES + 3), 1);
    check("timeout no strobe", q_byte.size(), 0);
    check("timeout byte kept", BYTE, 8'h08);
    CLK_MOUSE_IN = 1'b1;
    DATA_MOUSE_IN = 1'b1;
    tick(20);
    run_frame(8'hAA, 1'b1, 1'b1, "aa_after_timeout");

    // Reset in the middle of a frame
    send_frame(8'h5A, 1'b1, 1'b1, 7, 1'b1, -1);
    tick(3);
    RESET_N = 1'b0;
    #1;
    check("midreset BYTE", BYTE, 0);
    check("midreset ERR", BYTE_ERROR_CODE, 0);
    check("midreset BYTE_READ", BYTE_READ, 0);
    check("midreset FRAME_ABORT", FRAME_ABORT, 0);
    tick(3);
    CLK_MOUSE_IN = 1'b1;
    DATA_MOUSE_IN = 1'b1;
    tick(3);
    RESET_N = 1'b1;
    a0 = abort_cnt;
    tick(10);
    check("postreset no strobe", q_byte.size(), 0);
    check("postreset no abort", abort_cnt - a0, 0);
    run_frame(8'h00, 1'b1, 1'b1, "00_after_reset");

    // Reception disabled for a whole frame
    READ_ENABLE = 1'b0;
    a0 = abort_cnt;
    send_frame(8'h55, 1'b1, 1'b1, 11, 1'b0, -1);
    tick(8);
    check("re_off strobes", q_byte.size(), 0);
    check("re_off aborts", abort_cnt - a0, 0);
    READ_ENABLE = 1'b1;
    tick(5);

    // READ_ENABLE withdrawn after data bit 2
    a0 = abort_cnt;
    send_frame(8'h55, 1'b1, 1'b1, 11, 1'b0, 3);
    tick(8);
    check("re_drop aborts", abort_cnt - a0, 1);
    check("re_drop abort latency", abort_cyc - drop_cyc, 1);
    check("re_drop strobes", q_byte.size(), 0);
    READ_ENABLE = 1'b1;
    tick(5);

    // False start: data high at an idle fall
    a0 = abort_cnt;
    DATA_MOUSE_IN = 1'b1;
    tick(HALF);
    CLK_MOUSE_IN = 1'b0;
    tick(HALF);
    CLK_MOUSE_IN = 1'b1;
    tick(HALF);
    check("false start strobes", q_byte.size(), 0);
    check("false start aborts", abort_cnt - a0, 0);

    // Back-to-back frames
    run_frame(8'hF4, 1'b0, 1'b1, "f4_b2b");
    run_frame(8'hFA, 1'b1, 1'b1, "fa_b2b");

    // Random frames with occasional parity/stop corruption
    for (int k = 0; k < 20; k++) begin
      rd = 8'($urandom);
      rp = good_parity(rd) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 4) != 0);
      run_frame(rd, rp, rs, $sformatf("rand%0d", k));
    end

    check("never both strobes", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
